// File: rtl/cv32e40s_register_file_scrub_if.sv
// Read/write port bundle of the parity-protected register file.
// The core side drives addresses and write data; the register file returns read data and parity flags.
interface cv32e40s_register_file_scrub_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_WORDS       = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2
);
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS);

  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic [NUM_READ_PORTS-1:0]                  rdata_err_o;
  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WRITE_PORTS-1:0]                 we_i;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i,
    input  rdata_o, rdata_err_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i,
    output rdata_o, rdata_err_o
  );
endinterface

// File: rtl/cv32e40s_register_file_scrub.sv
// Register file with per-byte parity, checked reads and a background scrubber with a sticky error record.
// Optional same-cycle write-to-read bypass is enabled by defining CV32E40S_RF_BYPASS_EN.
module cv32e40s_register_file_scrub #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_WORDS       = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  cv32e40s_register_file_scrub_if.slave        rf,
  input  logic                                 scrub_en_i,
  output logic [$clog2(NUM_WORDS)-1:0]         scrub_idx_o,
  output logic                                 err_valid_o,
  output logic [$clog2(NUM_WORDS)-1:0]         err_addr_o,
  output logic                                 err_src_o,
  input  logic                                 err_clr_i,
  output logic                                 alert_o
);
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
  localparam int PAR_WIDTH  = DATA_WIDTH / 8;
  localparam int WORD_WIDTH = DATA_WIDTH + PAR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [PAR_WIDTH-1:0]  par_t;
  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic {IDLE, SCAN} state_e;

  // Odd bytes carry inverted parity so an all-zero word is never a legal encoding.
  function automatic par_t gen_par(data_t d);
    par_t p;
    for (int b = 0; b < PAR_WIDTH; b++) begin
      p[b] = (^d[8*b +: 8]) ^ b[0];
    end
    return p;
  endfunction

  function automatic logic word_ok(word_t w);
    return gen_par(w[DATA_WIDTH-1:0]) == w[WORD_WIDTH-1:DATA_WIDTH];
  endfunction

  function automatic logic addr_ok(addr_t a);
    return (a != '0) && (int'(a) < NUM_WORDS);
  endfunction

  localparam word_t RESET_WORD = {gen_par(data_t'(0)), data_t'(0)};
  localparam addr_t FIRST_IDX  = addr_t'(1);
  localparam addr_t LAST_IDX   = addr_t'(NUM_WORDS - 1);

  word_t  mem_q [NUM_WORDS];
  state_e state_q;
  addr_t  scrub_idx_q;
  logic   err_valid_q;
  addr_t  err_addr_q;
  logic   err_src_q;
  logic   alert_q;

  logic [NUM_WRITE_PORTS-1:0] wr_valid;
  logic                       scrub_hit;
  logic                       scrub_err;
  logic                       new_err;
  addr_t                      new_addr;
  logic                       new_src;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_valid = '0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      wr_valid[w] = rf.we_i[w] && addr_ok(rf.waddr_i[w]);
    end
  end

  always_comb begin
    rf.rdata_o     = '0;
    rf.rdata_err_o = '0;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      if (addr_ok(rf.raddr_i[r])) begin
        rf.rdata_o[r]     = mem_q[rf.raddr_i[r]][DATA_WIDTH-1:0];
        rf.rdata_err_o[r] = !word_ok(mem_q[rf.raddr_i[r]]);
`ifdef CV32E40S_RF_BYPASS_EN
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
          if (wr_valid[w] && (rf.waddr_i[w] == rf.raddr_i[r])) begin
            rf.rdata_o[r]     = rf.wdata_i[w];
            rf.rdata_err_o[r] = 1'b0;
          end
        end
`endif
      end
    end
  end

  // A word being rewritten this cycle is skipped: its stored copy is about to be replaced.
  always_comb begin
    scrub_hit = 1'b0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (rf.we_i[w] && (rf.waddr_i[w] == scrub_idx_q)) scrub_hit = 1'b1;
    end
    scrub_err = (state_q == SCAN) && scrub_en_i && !scrub_hit && !word_ok(mem_q[scrub_idx_q]);
  end

  // Descending walk leaves the lowest erroring read port as the reported source.
  always_comb begin
    new_err  = (|rf.rdata_err_o) || scrub_err;
    new_addr = scrub_idx_q;
    new_src  = 1'b1;
    for (int r = NUM_READ_PORTS - 1; r >= 0; r--) begin
      if (rf.rdata_err_o[r]) begin
        new_addr = rf.raddr_i[r];
        new_src  = 1'b0;
      end
    end
  end

  // NOTE: the array is reset like any other state because the all-zero pattern is itself a parity error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= RESET_WORD;
    end else begin
      // NOTE: non-blocking updates resolve in program order, so the highest write port lands last and wins.
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_valid[w]) mem_q[rf.waddr_i[w]] <= {gen_par(rf.wdata_i[w]), rf.wdata_i[w]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scrub_idx_q <= FIRST_IDX;
    end else begin
      case (state_q)
        IDLE: if (scrub_en_i) state_q <= SCAN;
        SCAN: begin
          if (!scrub_en_i) begin
            state_q <= IDLE;
          end else begin
            scrub_idx_q <= (scrub_idx_q == LAST_IDX) ? FIRST_IDX : scrub_idx_q + FIRST_IDX;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A coincident clear and new error re-arms the record with the new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_src_q   <= 1'b0;
      alert_q     <= 1'b0;
    end else begin
      alert_q <= new_err;
      if (new_err && (!err_valid_q || err_clr_i)) begin
        err_valid_q <= 1'b1;
        err_addr_q  <= new_addr;
        err_src_q   <= new_src;
      end else if (err_clr_i) begin
        err_valid_q <= 1'b0;
      end
    end
  end

  assign scrub_idx_o = scrub_idx_q;
  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_src_o   = err_src_q;
  assign alert_o     = alert_q;
endmodule
